vector_mem_sequencer: RTL and testbench

- Multi-cycle sequencer for vector memory instructions (VectorOp with MemWrite or MemToReg).
- Splits one vector load/store into LANES element accesses on the single-port data memory and stalls the pipeline until all accesses complete.
- Sits beside the memory stage, driven by decoded control signals; owns the data-memory port while busy.

---
 rtl/vec_mem_pkg.sv | 19 +
 rtl/vector_mem_sequencer.sv | 125 ++++++++++++
 tb/tb_vector_mem_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/vec_mem_pkg.sv
// Shared types and defaults for the vector memory sequencer.
package vec_mem_pkg;

  localparam int DEF_LANES  = 4;
  localparam int DEF_ELEM_W = 8;
  localparam int DEF_ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Width of the lane counter; LANES is a power of two >= 2.
  function automatic int lane_w(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage

// File: rtl/vector_mem_sequencer.sv
// Splits one vector load/store into LANES single-element accesses on the
// data-memory port and stalls the pipeline until the last access completes.
module vector_mem_sequencer
  import vec_mem_pkg::*;
#(
  parameter int LANES  = DEF_LANES,
  parameter int ELEM_W = DEF_ELEM_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    is_store,
  input  logic [ADDR_W-1:0]       base_addr,
  input  logic [LANES*ELEM_W-1:0] store_vec,
  output logic                    stall,
  output logic                    busy,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [ELEM_W-1:0]       mem_wdata,
  input  logic                    mem_ready,
  input  logic [ELEM_W-1:0]       mem_rdata,
  output logic [LANES*ELEM_W-1:0] load_vec,
  output logic                    load_valid,
  output logic                    done
);

  localparam int              LW   = lane_w(LANES);
  localparam int              VW   = LANES * ELEM_W;
  localparam logic [LW-1:0]   LAST = LW'(LANES - 1);

  // Memory handshake: an element access transfers in a cycle where
  // mem_req & mem_ready are both high; while mem_ready is low every
  // mem_* output holds its value and the lane does not advance.

  state_t            state_q, state_d;
  logic [LW-1:0]     lane_q;
  logic              is_store_q;
  logic [ADDR_W-1:0] base_q;
  logic [VW-1:0]     store_q;
  logic [VW-1:0]     shadow_q;
  logic [VW-1:0]     shadow_merged;
  logic [VW-1:0]     load_vec_q;
  logic              beat;
  logic              last_beat;

  assign beat      = (state_q == ACCESS) && mem_ready;
  assign last_beat = beat && (lane_q == LAST);

  // Shadow with the current beat's read data inserted, so the final beat
  // can land in load_vec without an extra cycle.
  always_comb begin
    shadow_merged = shadow_q;
    shadow_merged[int'(lane_q) * ELEM_W +: ELEM_W] = mem_rdata;
  end

  always_comb begin
    state_d    = state_q;
    stall      = 1'b0;
    busy       = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    done       = 1'b0;
    load_valid = 1'b0;
    case (state_q)
      IDLE: begin
        stall = start;
        if (start) state_d = ACCESS;
      end
      ACCESS: begin
        busy     = 1'b1;
        stall    = 1'b1;
        mem_req  = 1'b1;
        mem_we   = is_store_q;
        mem_addr = base_q + ADDR_W'(lane_q);
        if (is_store_q) mem_wdata = store_q[int'(lane_q) * ELEM_W +: ELEM_W];
        if (last_beat) state_d = DONE;
      end
      DONE: begin
        done       = 1'b1;
        load_valid = !is_store_q;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_q     <= '0;
      is_store_q <= 1'b0;
      base_q     <= '0;
      store_q    <= '0;
      shadow_q   <= '0;
      load_vec_q <= '0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: begin
          if (start) begin
            is_store_q <= is_store;
            base_q     <= base_addr;
            store_q    <= store_vec;
            lane_q     <= '0;
          end
        end
        ACCESS: begin
          if (beat) begin
            lane_q <= lane_q + LW'(1);
            if (!is_store_q) shadow_q <= shadow_merged;
            if (last_beat && !is_store_q) load_vec_q <= shadow_merged;
          end
        end
        default: ;
      endcase
    end
  end

  assign load_vec = load_vec_q;

endmodule

// File: tb/tb_vector_mem_sequencer.sv
// Self-checking bench for vector_mem_sequencer: scenario tasks plus a
// scoreboard of expected memory accesses and load results.
module tb_vector_mem_sequencer;

  localparam int LANES  = 4;
  localparam int ELEM_W = 8;
  localparam int ADDR_W = 32;
  localparam int VW     = LANES * ELEM_W;
  localparam int RW     = 1 + ADDR_W + ELEM_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              is_store;
  logic [ADDR_W-1:0] base_addr;
  logic [VW-1:0]     store_vec;
  logic              stall;
  logic              busy;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [ELEM_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [ELEM_W-1:0] mem_rdata;
  logic [VW-1:0]     load_vec;
  logic              load_valid;
  logic              done;

  logic [ELEM_W-1:0] mem [256];
  int                checks = 0;
  int                errors = 0;
  logic [RW-1:0]     exp_q[$];
  logic [VW-1:0]     exp_load_q[$];
  logic [RW-1:0]     acc_got, acc_exp;
  logic [VW-1:0]     lv_exp;

  vector_mem_sequencer #(.LANES(LANES), .ELEM_W(ELEM_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst), .start(start), .is_store(is_store),
    .base_addr(base_addr), .store_vec(store_vec), .stall(stall), .busy(busy),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
    .load_vec(load_vec), .load_valid(load_valid), .done(done)
  );

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr[7:0]];

  always @(negedge clk) begin
    if (mem_req === 1'b1 && mem_ready === 1'b1) begin
      acc_got = {mem_we, mem_addr, mem_wdata};
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL access_unexpected got=%h expected none", acc_got);
      end else begin
        acc_exp = exp_q.pop_front();
        if (acc_got !== acc_exp) begin
          errors++;
          $display("FAIL access got=%h expected=%h", acc_got, acc_exp);
        end
      end
    end
    if (load_valid === 1'b1) begin
      checks++;
      if (exp_load_q.size() == 0) begin
        errors++;
        $display("FAIL load_valid_unexpected load_vec=%h expected none", load_vec);
      end else begin
        lv_exp = exp_load_q.pop_front();
        if (load_vec !== lv_exp) begin
          errors++;
          $display("FAIL load_vec got=%h expected=%h", load_vec, lv_exp);
        end
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; is_store = 1'b0; base_addr = '0;
    store_vec = '0; mem_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, busy, mem_req, mem_we, load_valid, done} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got=%b expected=000000",
               {stall, busy, mem_req, mem_we, load_valid, done});
    end
    checks++;
    if (mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset_mem got addr=%h wdata=%h expected 0", mem_addr, mem_wdata);
    end
    checks++;
    if (load_vec !== '0) begin
      errors++;
      $display("FAIL reset_load_vec got=%h expected=0", load_vec);
    end
  endtask

  task automatic test_load();
    for (int i = 0; i < LANES; i++) exp_q.push_back({1'b0, 32'(32'h10 + i), 8'h00});
    exp_load_q.push_back(32'h44332211);
    cyc();
    start = 1'b1; is_store = 1'b0; base_addr = 32'h10; store_vec = $urandom;
    @(negedge clk);
    checks++;
    if ({stall, busy, mem_req} !== 3'b100) begin
      errors++;
      $display("FAIL load_c0 stall/busy/req got=%b expected=100", {stall, busy, mem_req});
    end
    for (int c = 1; c <= LANES; c++) begin
      cyc();
      start = 1'b0; base_addr = $urandom; is_store = 1'b1;
      @(negedge clk);
      checks++;
      if ({stall, busy, mem_req, mem_we} !== 4'b1110 || mem_addr !== 32'(32'h10 + c - 1)) begin
        errors++;
        $display("FAIL load_access c=%0d got ctrl=%b addr=%h expected ctrl=1110 addr=%h",
                 c, {stall, busy, mem_req, mem_we}, mem_addr, 32'(32'h10 + c - 1));
      end
    end
    cyc();
    is_store = 1'b0;
    @(negedge clk);
    checks++;
    if ({done, load_valid, stall, busy, mem_req} !== 5'b11000 || load_vec !== 32'h44332211) begin
      errors++;
      $display("FAIL load_done got ctrl=%b vec=%h expected ctrl=11000 vec=44332211",
               {done, load_valid, stall, busy, mem_req}, load_vec);
    end
    cyc();
    @(negedge clk);
    checks++;
    if ({done, load_valid} !== 2'b00 || load_vec !== 32'h44332211) begin
      errors++;
      $display("FAIL load_after got done/lv=%b vec=%h expected 00 vec=44332211",
               {done, load_valid}, load_vec);
    end
  endtask

  task automatic test_store_backpressure();
    logic [VW-1:0] sv;
    sv = 32'hDDCCBBAA;
    for (int i = 0; i < LANES; i++)
      exp_q.push_back({1'b1, 32'(32'h20 + i), sv[i*ELEM_W +: ELEM_W]});
    cyc();
    start = 1'b1; is_store = 1'b1; base_addr = 32'h20; store_vec = sv;
    for (int c = 1; c <= 7; c++) begin
      cyc();
      start = 1'b0; store_vec = $urandom; base_addr = $urandom;
      mem_ready = !(c == 2 || c == 3);
      @(negedge clk);
      if (c == 2 || c == 3) begin
        checks++;
        if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h21 || mem_wdata !== 8'hBB) begin
          errors++;
          $display("FAIL store_hold c=%0d got req=%b we=%b addr=%h wdata=%h expected 1 1 00000021 bb",
                   c, mem_req, mem_we, mem_addr, mem_wdata);
        end
      end
      if (c == 6 || c == 7) begin
        checks++;
        if (done !== (c == 7) || busy !== (c != 7) || load_valid !== 1'b0) begin
          errors++;
          $display("FAIL store_done c=%0d got done=%b busy=%b lv=%b expected done=%0d busy=%0d lv=0",
                   c, done, busy, load_valid, (c == 7), (c != 7));
        end
      end
    end
    mem_ready = 1'b1;
    checks++;
    if (load_vec !== 32'h44332211) begin
      errors++;
      $display("FAIL store_load_vec got=%h expected=44332211", load_vec);
    end
  endtask

  task automatic test_wrap();
    logic [VW-1:0] ev;
    logic [ADDR_W-1:0] a;
    int n;
    bit got_done;
    for (int i = 0; i < LANES; i++) begin
      a = 32'hFFFF_FFFE + 32'(i);
      mem[a[7:0]] = 8'($urandom_range(0, 255));
      ev[i*ELEM_W +: ELEM_W] = mem[a[7:0]];
      exp_q.push_back({1'b0, a, 8'h00});
    end
    exp_load_q.push_back(ev);
    cyc();
    start = 1'b1; is_store = 1'b0; base_addr = 32'hFFFF_FFFE;
    n = 0; got_done = 1'b0;
    while (!got_done && n < 20) begin
      cyc();
      start = 1'b0;
      n++;
      @(negedge clk);
      if (done === 1'b1) got_done = 1'b1;
    end
    checks++;
    if (!got_done || n != LANES + 1 || load_vec !== ev) begin
      errors++;
      $display("FAIL wrap got done_cycle=%0d vec=%h expected done_cycle=%0d vec=%h",
               got_done ? n : -1, load_vec, LANES + 1, ev);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, 32'(32'h50 + i), 8'h00});
    cyc();
    start = 1'b1; is_store = 1'b0; base_addr = 32'h50;
    cyc(); start = 1'b0;
    cyc();
    cyc(); rst = 1'b1;
    cyc(); rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({stall, busy, mem_req, mem_we, load_valid, done} !== 6'b0 || load_vec !== '0) begin
      errors++;
      $display("FAIL reset_mid got ctrl=%b vec=%h expected ctrl=000000 vec=0",
               {stall, busy, mem_req, mem_we, load_valid, done}, load_vec);
    end
    for (int c = 0; c < 3; c++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (mem_req !== 1'b0 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_idle c=%0d got req=%b busy=%b expected 0 0", c, mem_req, busy);
      end
    end
    test_load();
  endtask

  task automatic test_rst_start();
    cyc();
    rst = 1'b1; start = 1'b1; is_store = 1'b0; base_addr = 32'h60;
    cyc();
    rst = 1'b0; start = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++;
      if ({stall, busy, mem_req, done} !== 4'b0) begin
        errors++;
        $display("FAIL rst_start c=%0d got ctrl=%b expected=0000", c, {stall, busy, mem_req, done});
      end
      cyc();
    end
  endtask

  task automatic test_back_to_back();
    logic [VW-1:0] sv;
    int dones;
    int first_done, second_done;
    sv = 32'h04030201;
    for (int i = 0; i < LANES; i++)
      exp_q.push_back({1'b1, 32'(32'h40 + i), sv[i*ELEM_W +: ELEM_W]});
    for (int i = 0; i < LANES; i++) exp_q.push_back({1'b0, 32'(32'h10 + i), 8'h00});
    exp_load_q.push_back(32'h44332211);
    dones = 0; first_done = -1; second_done = -1;
    for (int c = 0; c < 15; c++) begin
      cyc();
      if (c <= 5) begin
        start = 1'b1; is_store = 1'b1; base_addr = 32'h40; store_vec = sv;
      end else if (c == 6) begin
        start = 1'b1; is_store = 1'b0; base_addr = 32'h10; store_vec = $urandom;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      if (done === 1'b1) begin
        dones++;
        if (first_done < 0) first_done = c;
        else second_done = c;
      end
      if (c == 5) begin
        checks++;
        if (stall !== 1'b0) begin
          errors++;
          $display("FAIL b2b_done_stall got=%b expected=0", stall);
        end
      end
    end
    checks++;
    if (dones != 2 || first_done != 5 || second_done != 11) begin
      errors++;
      $display("FAIL b2b_done got count=%0d at %0d,%0d expected 2 at 5,11",
               dones, first_done, second_done);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    for (int i = 0; i < 4; i++) mem[8'h50 + i] = 8'($urandom_range(0, 255));
    test_reset();
    test_load();
    test_store_backpressure();
    test_wrap();
    test_reset_mid();
    test_rst_start();
    test_back_to_back();
    repeat (2) cyc();
    checks++;
    if (exp_q.size() != 0 || exp_load_q.size() != 0) begin
      errors++;
      $display("FAIL leftover got acc=%0d loads=%0d expected 0 0", exp_q.size(), exp_load_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
